// File: rtl/pipe_ctl_pkg.sv
// pipe_ctl_pkg: opcodes, ALUOp encodings and control-bundle layout
// shared by the pipeline controller and its decoder.
package pipe_ctl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       regDst;
        logic       aluSrc;
        logic [1:0] aluOp;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic       memToReg;
        logic       regWrite;
    } ctlBundle_t;

    localparam ctlBundle_t CTL_NOP = '0;
endpackage

// File: rtl/pipe_ctl_decode.sv
// ctl_decode: combinational ID-stage decode of the opcode into a control bundle,
// plus whether the instruction reads rt as a source.
module ctl_decode
    import pipe_ctl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           valid,
    input  logic [OPW-1:0] op,
    output ctlBundle_t     ctl,
    output logic           usesRt
);
    localparam ctlBundle_t CTL_R   = '{1'b1, 1'b0, ALUOP_FUNCT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam ctlBundle_t CTL_LW  = '{1'b0, 1'b1, ALUOP_ADD,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam ctlBundle_t CTL_SW  = '{1'b0, 1'b1, ALUOP_ADD,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam ctlBundle_t CTL_BEQ = '{1'b0, 1'b0, ALUOP_SUB,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    logic isR, isLw, isSw, isBeq;

    always_comb begin
        isR    = valid && op == OPW'(OP_RTYPE);
        isLw   = valid && op == OPW'(OP_LW);
        isSw   = valid && op == OPW'(OP_SW);
        isBeq  = valid && op == OPW'(OP_BEQ);
        ctl    = isR ? CTL_R : isLw ? CTL_LW : isSw ? CTL_SW : isBeq ? CTL_BEQ : CTL_NOP;
        usesRt = isR || isSw || isBeq;
    end
endmodule

// File: rtl/pipe_ctl.sv
// pipe_ctl: pipelined control for a 5-stage core -- stage registers, load-use
// stall, branch/jump flush and a saturating stall counter.
module pipe_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int RW  = 5,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic [OPW-1:0] id_op,
    input  logic [RW-1:0]  id_rs,
    input  logic [RW-1:0]  id_rt,
    input  logic [RW-1:0]  ex_rt,
    input  logic           mem_zero,
    output logic           ex_regdst,
    output logic           ex_alusrc,
    output logic [1:0]     ex_aluop,
    output logic           mem_read,
    output logic           mem_write,
    output logic           mem_branch,
    output logic           wb_memtoreg,
    output logic           wb_regwrite,
    output logic           pc_write,
    output logic           ifid_write,
    output logic           if_flush,
    output logic           pc_src_branch,
    output logic           pc_src_jump,
    output logic [CW-1:0]  stall_cnt
);
    ctlBundle_t idCtl, idExQ, exMemQ, memWbQ;
    logic usesRt, loadUse, branchTaken, stall, isJump;

    ctl_decode #(.OPW(OPW)) u_decode (
        .valid (id_valid),
        .op    (id_op),
        .ctl   (idCtl),
        .usesRt(usesRt)
    );

    // A taken branch overrides a stall; a stall in turn suppresses a jump.
    always_comb begin
        loadUse       = id_valid && idExQ.memRead && (ex_rt == id_rs || (ex_rt == id_rt && usesRt));
        branchTaken   = exMemQ.branch && mem_zero;
        stall         = loadUse && !branchTaken;
        isJump        = id_valid && id_op == OPW'(OP_J) && !branchTaken && !stall;
        pc_write      = !stall;
        ifid_write    = !stall;
        pc_src_branch = branchTaken;
        pc_src_jump   = isJump;
        if_flush      = branchTaken || isJump;
        ex_regdst     = idExQ.regDst;
        ex_alusrc     = idExQ.aluSrc;
        ex_aluop      = idExQ.aluOp;
        mem_read      = exMemQ.memRead;
        mem_write     = exMemQ.memWrite;
        mem_branch    = exMemQ.branch;
        wb_memtoreg   = memWbQ.memToReg;
        wb_regwrite   = memWbQ.regWrite;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idExQ     <= CTL_NOP;
            exMemQ    <= CTL_NOP;
            memWbQ    <= CTL_NOP;
            stall_cnt <= '0;
        end else begin
            idExQ     <= (branchTaken || stall) ? CTL_NOP : idCtl;
            exMemQ    <= branchTaken ? CTL_NOP : idExQ;
            memWbQ    <= exMemQ;
            stall_cnt <= (stall && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
        end
    end
endmodule

// File: tb/tb_pipe_ctl.sv
// tb_pipe_ctl: directed vectors with a scoreboard queue; a negedge monitor
// compares the packed output vector against each queued expectation.
module tb_pipe_ctl;
    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, J = 6'b000010;
    localparam logic [4:0] RUN = 5'b11000, STL = 5'b00000, BRT = 5'b11110, JMP = 5'b11101;

    logic clk = 1'b0, rst_n = 1'b1;
    logic idValid = 1'b0, memZero = 1'b0;
    logic [5:0] idOp = '0;
    logic [4:0] idRs = '0, idRt = '0, exRt = '0;
    logic exRegdst, exAlusrc, memRead, memWrite, memBranch, wbMemtoreg, wbRegwrite;
    logic pcWrite, ifidWrite, ifFlush, pcSrcBranch, pcSrcJump;
    logic [1:0] exAluop, stallCnt;
    logic [15:0] actual;

    string nameQ[$];
    logic [15:0] expQ[$];
    int checks = 0, errors = 0;

    pipe_ctl #(.CW(2)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_op(idOp), .id_rs(idRs), .id_rt(idRt),
        .ex_rt(exRt), .mem_zero(memZero), .ex_regdst(exRegdst), .ex_alusrc(exAlusrc), .ex_aluop(exAluop),
        .mem_read(memRead), .mem_write(memWrite), .mem_branch(memBranch), .wb_memtoreg(wbMemtoreg),
        .wb_regwrite(wbRegwrite), .pc_write(pcWrite), .ifid_write(ifidWrite), .if_flush(ifFlush),
        .pc_src_branch(pcSrcBranch), .pc_src_jump(pcSrcJump), .stall_cnt(stallCnt)
    );

    always #5 clk = ~clk;

    assign actual = {exRegdst, exAlusrc, exAluop, memRead, memWrite, memBranch, wbMemtoreg, wbRegwrite,
                     pcWrite, ifidWrite, ifFlush, pcSrcBranch, pcSrcJump, stallCnt};

    function automatic logic [15:0] ev(logic [3:0] ex, logic [2:0] mem, logic [1:0] wb, logic [4:0] c, logic [1:0] n);
        return {ex, mem, wb, c, n};
    endfunction

    task automatic step(string name, logic v, logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                        logic [4:0] er, logic mz, logic [15:0] e);
        @(posedge clk);
        #1;
        idValid = v; idOp = op; idRs = rs; idRt = rt; exRt = er; memZero = mz;
        nameQ.push_back(name);
        expQ.push_back(e);
    endtask

    task automatic idle(string name, logic [15:0] e);
        step(name, 1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0, e);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; idValid = 1'b0; idOp = '0; idRs = '0; idRt = '0; exRt = '0; memZero = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            automatic string n = nameQ.pop_front();
            automatic logic [15:0] e = expQ.pop_front();
            checks++;
            if (actual !== e) begin
                errors++;
                $display("FAIL %s got %b exp %b", n, actual, e);
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        idle("reset", ev(4'b0000, 3'b000, 2'b00, RUN, 2'd0));
        doReset();

        step("seq_lw",   1'b1, LW,  5'd1, 5'd2, 5'd0, 1'b0, ev(4'b0000, 3'b000, 2'b00, RUN, 2'd0));
        step("seq_add",  1'b1, R,   5'd3, 5'd4, 5'd2, 1'b0, ev(4'b0100, 3'b000, 2'b00, RUN, 2'd0));
        step("seq_sw",   1'b1, SW,  5'd5, 5'd6, 5'd4, 1'b0, ev(4'b1010, 3'b100, 2'b00, RUN, 2'd0));
        step("seq_beq",  1'b1, BEQ, 5'd7, 5'd8, 5'd6, 1'b0, ev(4'b0100, 3'b000, 2'b11, RUN, 2'd0));
        idle("seq_d1", ev(4'b0001, 3'b010, 2'b01, RUN, 2'd0));
        idle("seq_d2", ev(4'b0000, 3'b001, 2'b00, RUN, 2'd0));
        idle("seq_d3", ev(4'b0000, 3'b000, 2'b00, RUN, 2'd0));

        doReset();
        step("lu_lw",    1'b1, LW, 5'd1, 5'd5, 5'd0, 1'b0, ev(4'b0000, 3'b000, 2'b00, RUN, 2'd0));
        step("lu_stall", 1'b1, R,  5'd5, 5'd9, 5'd5, 1'b0, ev(4'b0100, 3'b000, 2'b00, STL, 2'd0));
        step("lu_bubble",1'b1, R,  5'd5, 5'd9, 5'd5, 1'b0, ev(4'b0000, 3'b100, 2'b00, RUN, 2'd1));
        idle("lu_add_ex", ev(4'b1010, 3'b000, 2'b11, RUN, 2'd1));

        doReset();
        step("rtdst_lw1", 1'b1, LW, 5'd1, 5'd5, 5'd0, 1'b0, ev(4'b0000, 3'b000, 2'b00, RUN, 2'd0));
        step("rtdst_lw2", 1'b1, LW, 5'd2, 5'd5, 5'd5, 1'b0, ev(4'b0100, 3'b000, 2'b00, RUN, 2'd0));
        step("rtdst_ex",  1'b0, R,  5'd0, 5'd0, 5'd5, 1'b0, ev(4'b0100, 3'b100, 2'b00, RUN, 2'd0));

        doReset();
        step("br_beq",   1'b1, BEQ, 5'd1, 5'd2, 5'd0, 1'b0, ev(4'b0000, 3'b000, 2'b00, RUN, 2'd0));
        step("br_lw",    1'b1, LW,  5'd3, 5'd5, 5'd2, 1'b0, ev(4'b0001, 3'b000, 2'b00, RUN, 2'd0));
        step("br_taken", 1'b1, R,   5'd5, 5'd6, 5'd5, 1'b1, ev(4'b0100, 3'b001, 2'b00, BRT, 2'd0));
        idle("br_flushed", ev(4'b0000, 3'b000, 2'b00, RUN, 2'd0));

        doReset();
        step("jmp",       1'b1, J, 5'd0, 5'd0, 5'd3, 1'b0, ev(4'b0000, 3'b000, 2'b00, JMP, 2'd0));
        step("jmp_inval", 1'b0, J, 5'd0, 5'd0, 5'd0, 1'b0, ev(4'b0000, 3'b000, 2'b00, RUN, 2'd0));
        idle("jmp_mem", ev(4'b0000, 3'b000, 2'b00, RUN, 2'd0));

        doReset();
        for (int i = 0; i < 5; i++) begin
            automatic logic [1:0] n = (i > 3) ? 2'd3 : 2'(i);
            step($sformatf("sat_lw%0d", i), 1'b1, LW, 5'd0, 5'd5, 5'd5, 1'b0,
                 ev(4'b0000, (i == 0) ? 3'b000 : 3'b100, 2'b00, RUN, n));
            step($sformatf("sat_stall%0d", i), 1'b1, R, 5'd5, 5'd1, 5'd5, 1'b0,
                 ev(4'b0100, 3'b000, (i == 0) ? 2'b00 : 2'b11, STL, n));
        end
        step("sat_hold", 1'b1, LW, 5'd0, 5'd5, 5'd5, 1'b0, ev(4'b0000, 3'b100, 2'b00, RUN, 2'd3));
        step("async_rst", 1'b1, R, 5'd5, 5'd1, 5'd5, 1'b0, ev(4'b0000, 3'b000, 2'b00, RUN, 2'd0));
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idValid = 1'b0;
        nameQ.push_back("post_rst");
        expQ.push_back(ev(4'b0000, 3'b000, 2'b00, RUN, 2'd0));

        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctl.md
PIPE_CTL -- requirements
Module: pipe_ctl

Interface
REQ-001 Parameter OPW, default 6, opcode width.
REQ-002 Parameter RW, default 5, register-address width.
REQ-003 Parameter CW, default 16, stall-counter width.
REQ-004 Clocking SHALL be one clock, with an asynchronous active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 id_valid  in  1  ID stage holds a real instruction.
REQ-008 id_op  in  OPW  ID-stage opcode.
REQ-009 id_rs, id_rt  in  RW each  ID-stage source register fields.
REQ-010 ex_rt  in  RW  rt field of the instruction in EX.
REQ-011 mem_zero  in  1  ALU zero flag of the instruction in MEM.
REQ-012 ex_regdst, ex_alusrc  out  1 each  EX-stage controls.
REQ-013 ex_aluop  out  2  EX-stage ALU op, as {ALUOp1,ALUOp0}.
REQ-014 mem_read, mem_write, mem_branch  out  1 each  MEM-stage controls.
REQ-015 wb_memtoreg, wb_regwrite  out  1 each  WB-stage controls.
REQ-016 pc_write, ifid_write  out  1 each  enables for PC and IF/ID; low means hold.
REQ-017 if_flush  out  1  squash IF/ID.
REQ-018 pc_src_branch, pc_src_jump  out  1 each  next-PC select.
REQ-019 stall_cnt  out  CW  saturating count of load-use stall cycles.

Function
REQ-020 Decode SHALL be combinational in ID and give {RegDst,ALUSrc,ALUOp,MemRead,MemWrite,Branch,MemtoReg,RegWrite} as follows:
- R-type (000000): 1,0,10,0,0,0,0,1
- lw (100011): 0,1,00,1,0,0,1,1
- sw (101011): 0,1,00,0,1,0,0,0
- beq (000100): 0,0,01,0,0,1,0,0
- jump (000010): all 0
- other opcodes: all 0
REQ-021 The control bundle SHALL advance ID/EX -> EX/MEM -> MEM/WB, one register per stage per clock; a control appears on its stage output 1, 2 or 3 cycles after ID.
REQ-022 Load-use hazard = id_valid & mem_read-of-EX-register (ID/EX MemRead) & (ex_rt==id_rs | (ex_rt==id_rt & op uses rt as source: R-type, sw, beq)).
REQ-023 On load-use hazard, pc_write and ifid_write SHALL be 0 and ID/EX SHALL load an all-zero bundle (bubble); EX/MEM and MEM/WB SHALL advance normally.
REQ-024 branch_taken = EX/MEM Branch & mem_zero; when asserted, pc_src_branch=1 and if_flush=1, and ID/EX and EX/MEM SHALL load zero bundles at the next edge.
REQ-025 Jump: when id_valid & id_op==jump & no branch_taken, pc_src_jump=1 and if_flush=1 in the same cycle.
REQ-026 Priority SHALL be branch_taken > load-use stall > jump; during branch_taken, pc_write=1, ifid_write=1, and pc_src_jump=0.
REQ-027 id_valid=0 SHALL decode as an all-zero bundle with no hazard.
REQ-028 stall_cnt SHALL increment by 1 per load-use stall cycle (REQ-023 applied) and saturate at 2^CW-1; it SHALL not wrap.
REQ-029 A flush caused by branch_taken SHALL not count as a stall.
REQ-030 With no hazard, flush or jump: pc_write=1, ifid_write=1, if_flush=0, pc_src_*=0.

Reset
REQ-031 rst_n low SHALL asynchronously clear all three pipeline registers and stall_cnt to 0; all stage outputs read 0 while reset is held.
REQ-032 Reset asserted mid-stall or mid-flush SHALL discard that state; the first edge after release with no hazard behaves per REQ-030.

Structure
REQ-033 A shared package SHALL hold the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J), the ALUOp encodings, and the control-bundle field layout.
REQ-034 Decode SHALL be one sub-module, ctl_decode (combinational); pipe_ctl instantiates it and owns the registers, hazard logic and counter.

Verification
REQ-035 Reset then lw,add,sw,beq issued back-to-back with no dependencies -> each bundle per REQ-020 appears 1/2/3 cycles later; stall_cnt=0.
REQ-036 lw with ex_rt=5, followed by add with id_rs=5 -> exactly one cycle with pc_write=0, ifid_write=0 and a zero ID/EX bundle; stall_cnt=1.
REQ-037 lw with ex_rt=5, followed by lw with id_rt=5 (rt is the destination) -> no stall.
REQ-038 beq in MEM with mem_zero=1 while a load-use hazard is present in ID -> pc_src_branch=1, if_flush=1, pc_write=1, then zero EX/MEM and ID/EX bundles; stall_cnt unchanged.
REQ-039 jump in ID -> pc_src_jump=1 and if_flush=1 the same cycle; all its stage controls are 0.
REQ-040 CW=2 with 5 consecutive stall cycles -> stall_cnt=3 (saturated); rst_n pulsed low mid-stall -> all outputs 0 asynchronously.
